// File: rtl/router_pkg.sv
// Shared constants for the router datapath: byte width, reserved address and
// header field positions.
package router_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic [1:0] ADDR_INVALID = 2'b11;

   localparam int unsigned ADDR_LSB = 0;
   localparam int unsigned ADDR_MSB = 1;
   localparam int unsigned LEN_LSB  = 2;
   localparam int unsigned LEN_MSB  = 7;

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes, plus the registered compare against
// the received parity byte that drives err.
module router_parity_acc #(
   parameter int unsigned DATA_W = router_pkg::DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              full_state,
   input  logic              pkt_valid,
   input  logic              parity_done,
   input  logic [DATA_W-1:0] header_byte,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] pkt_parity,
   output logic              err
);

   logic [DATA_W-1:0] int_parity_d, int_parity_q;
   logic              err_d, err_q;

   always_comb begin
      int_parity_d = int_parity_q;
      if (detect_add) begin
         int_parity_d = '0;
      end else if (lfd_state) begin
         int_parity_d = int_parity_q ^ header_byte;
      end else if (ld_state && pkt_valid && !full_state) begin
         // A stalled byte is taken here on its LOAD_DATA cycle, never again in laf_state.
         int_parity_d = int_parity_q ^ data_in;
      end

      err_d = err_q;
      if (detect_add) begin
         err_d = 1'b0;
      end else if (parity_done) begin
         err_d = (pkt_parity != int_parity_q);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         int_parity_q <= '0;
         err_q        <= 1'b0;
      end else begin
         int_parity_q <= int_parity_d;
         err_q        <= err_d;
      end
   end

   assign err = err_q;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header/hold capture, FIFO byte mux and the
// packet-status flags fed back to router_fsm.
module router_reg
   import router_pkg::*;
#(
   parameter int unsigned DATA_W = router_pkg::DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              rst_int_reg,
   output logic [DATA_W-1:0] dout,
   output logic              parity_done,
   output logic              low_pkt_valid,
   output logic              err
);

   logic [DATA_W-1:0] header_d, header_q;
   logic [DATA_W-1:0] hold_d, hold_q;
   logic [DATA_W-1:0] dout_d, dout_q;
   logic [DATA_W-1:0] pkt_parity_d, pkt_parity_q;
   logic              low_d, low_q;
   logic              pdone_d, pdone_q;
   logic              laf_parity;

   always_comb begin
      header_d = header_q;
      if (detect_add && pkt_valid && (data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID)) begin
         header_d = data_in;
      end

      hold_d = hold_q;
      if (ld_state && fifo_full) begin
         hold_d = data_in;
      end

      dout_d = dout_q;
      if (lfd_state) begin
         dout_d = header_q;
      end else if (ld_state && !fifo_full) begin
         dout_d = data_in;
      end else if (laf_state) begin
         dout_d = hold_q;
      end

      // Parity byte that met a full FIFO sits in hold_q and is taken on the laf cycle.
      laf_parity = laf_state && low_q && !pdone_q;

      pkt_parity_d = pkt_parity_q;
      if (ld_state && !pkt_valid && !fifo_full) begin
         pkt_parity_d = data_in;
      end else if (laf_parity) begin
         pkt_parity_d = hold_q;
      end

      low_d = low_q;
      if (ld_state && !pkt_valid) begin
         low_d = 1'b1;
      end else if (rst_int_reg) begin
         low_d = 1'b0;
      end

      pdone_d = pdone_q;
      if (detect_add) begin
         pdone_d = 1'b0;
      end else if ((ld_state && !fifo_full && !pkt_valid) || laf_parity) begin
         pdone_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         header_q     <= '0;
         hold_q       <= '0;
         dout_q       <= '0;
         pkt_parity_q <= '0;
         low_q        <= 1'b0;
         pdone_q      <= 1'b0;
      end else begin
         header_q     <= header_d;
         hold_q       <= hold_d;
         dout_q       <= dout_d;
         pkt_parity_q <= pkt_parity_d;
         low_q        <= low_d;
         pdone_q      <= pdone_d;
      end
   end

   router_parity_acc #(
      .DATA_W (DATA_W)
   ) u_parity_acc (
      .clock       (clock),
      .reset       (reset),
      .detect_add  (detect_add),
      .lfd_state   (lfd_state),
      .ld_state    (ld_state),
      .full_state  (full_state),
      .pkt_valid   (pkt_valid),
      .parity_done (pdone_q),
      .header_byte (header_q),
      .data_in     (data_in),
      .pkt_parity  (pkt_parity_q),
      .err         (err)
   );

   assign dout          = dout_q;
   assign parity_done   = pdone_q;
   assign low_pkt_valid = low_q;

endmodule

// File: tb/tb_router_reg.sv
// Packet-level bench for router_reg: emulates router_fsm strobe sequences and
// checks bytes and status flags against expectations derived per packet.
module tb_router_reg;

   logic       clock;
   logic       reset;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic       fifo_full;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic [7:0] dout;
   logic       parity_done, low_pkt_valid, err;

   int checks   = 0;
   int failures = 0;

   logic [7:0] pl [64];
   int         pl_len;
   logic [7:0] last_dout;
   logic [7:0] last_hdr;

   router_reg dut (
      .clock         (clock),
      .reset         (reset),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .rst_int_reg   (rst_int_reg),
      .dout          (dout),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .err           (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      detect_add  = 1'b0;
      lfd_state   = 1'b0;
      ld_state    = 1'b0;
      laf_state   = 1'b0;
      full_state  = 1'b0;
      rst_int_reg = 1'b0;
      fifo_full   = 1'b0;
      pkt_valid   = 1'b0;
      data_in     = 8'($urandom);
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic full_wait(input int k, input bit pv);
      for (int j = 0; j < k; j++) begin
         set_idle();
         full_state = 1'b1;
         fifo_full  = 1'b1;
         pkt_valid  = pv;
         cyc();
         chk("full_dout", dout, last_dout);
         chk("full_pdone", 8'(parity_done), 8'h00);
      end
   endtask

   // One packet as router_fsm would sequence it; expectations come from packet contents.
   task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par, input int stall_at,
                           input int stall_cycles, input bit stall_par);
      logic [7:0] xsum;
      logic       exp_err;
      xsum = hdr;
      for (int i = 0; i < pl_len; i++) xsum = xsum ^ pl[i];
      exp_err = (par != xsum);

      set_idle();
      detect_add = 1'b1;
      pkt_valid  = 1'b1;
      data_in    = hdr;
      cyc();
      chk("da_pdone", 8'(parity_done), 8'h00);
      chk("da_err", 8'(err), 8'h00);
      chk("da_dout", dout, last_dout);
      if (hdr[1:0] != 2'b11) last_hdr = hdr;

      set_idle();
      lfd_state = 1'b1;
      pkt_valid = 1'b1;
      data_in   = pl[0];
      cyc();
      chk("lfd_dout", dout, last_hdr);
      last_dout = last_hdr;

      for (int i = 0; i < pl_len; i++) begin
         set_idle();
         ld_state  = 1'b1;
         pkt_valid = 1'b1;
         data_in   = pl[i];
         fifo_full = (i == stall_at);
         cyc();
         if (i != stall_at) begin
            chk("ld_dout", dout, pl[i]);
         end else begin
            chk("stall_dout", dout, last_dout);
            full_wait(stall_cycles, 1'b1);
            set_idle();
            laf_state = 1'b1;
            pkt_valid = 1'b1;
            cyc();
            chk("laf_dout", dout, pl[i]);
            chk("laf_pdone", 8'(parity_done), 8'h00);
         end
         last_dout = pl[i];
         chk("ld_low", 8'(low_pkt_valid), 8'h00);
      end

      set_idle();
      ld_state  = 1'b1;
      data_in   = par;
      fifo_full = stall_par;
      cyc();
      chk("par_low", 8'(low_pkt_valid), 8'h01);
      if (!stall_par) begin
         chk("par_pdone", 8'(parity_done), 8'h01);
         chk("par_dout", dout, par);
      end else begin
         chk("parst_pdone", 8'(parity_done), 8'h00);
         chk("parst_dout", dout, last_dout);
         full_wait(stall_cycles, 1'b0);
         set_idle();
         laf_state = 1'b1;
         cyc();
         chk("parlaf_pdone", 8'(parity_done), 8'h01);
         chk("parlaf_dout", dout, par);
         chk("parlaf_low", 8'(low_pkt_valid), 8'h01);
      end
      last_dout = par;
      chk("par_err_early", 8'(err), 8'h00);

      set_idle();
      rst_int_reg = 1'b1;
      cyc();
      chk("cpe_low", 8'(low_pkt_valid), 8'h00);
      chk("cpe_err", 8'(err), 8'(exp_err));
      chk("cpe_pdone", 8'(parity_done), 8'h01);

      set_idle();
      cyc();
      chk("idle_err", 8'(err), 8'(exp_err));
      chk("idle_pdone", 8'(parity_done), 8'h01);
      chk("idle_dout", dout, last_dout);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dout"}, dout, 8'h00);
      chk({tag, "_pdone"}, 8'(parity_done), 8'h00);
      chk({tag, "_low"}, 8'(low_pkt_valid), 8'h00);
      chk({tag, "_err"}, 8'(err), 8'h00);
   endtask

   task automatic load_std();
      pl_len = 3;
      pl[0]  = 8'h11;
      pl[1]  = 8'h22;
      pl[2]  = 8'h33;
   endtask

   initial begin
      reset = 1'b0;
      set_idle();
      last_dout = 8'h00;
      last_hdr  = 8'h00;
      #1 reset = 1'b1;
      #1 chk_all_zero("rst0");
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      load_std();
      send_pkt(8'h0D, 8'h0D, -1, 0, 1'b0);
      send_pkt(8'h0D, 8'h0E, -1, 0, 1'b0);
      send_pkt(8'h0D, 8'h0D, 1, 1, 1'b0);
      send_pkt(8'h0D, 8'h0D, -1, 1, 1'b1);

      // Reserved address: header register must keep the previous header.
      set_idle();
      detect_add = 1'b1;
      pkt_valid  = 1'b1;
      data_in    = 8'h0F;
      cyc();
      chk("inv_dout", dout, last_dout);
      set_idle();
      lfd_state = 1'b1;
      cyc();
      chk("inv_hdr", dout, last_hdr);
      last_dout = last_hdr;

      // Reset in the middle of a payload.
      set_idle();
      detect_add = 1'b1;
      pkt_valid  = 1'b1;
      data_in    = 8'h0D;
      cyc();
      set_idle();
      lfd_state = 1'b1;
      pkt_valid = 1'b1;
      data_in   = 8'h11;
      cyc();
      set_idle();
      ld_state  = 1'b1;
      pkt_valid = 1'b1;
      data_in   = 8'h11;
      cyc();
      chk("mid_dout", dout, 8'h11);
      #2 reset = 1'b1;
      #1 chk_all_zero("rstmid");
      @(negedge clock);
      reset = 1'b0;
      set_idle();
      last_dout = 8'h00;
      last_hdr  = 8'h00;
      load_std();
      send_pkt(8'h0D, 8'h0D, -1, 0, 1'b0);

      for (int n = 0; n < 25; n++) begin
         logic [7:0] hdr;
         logic [7:0] xs;
         logic [7:0] par;
         pl_len = int'($urandom_range(1, 8));
         hdr    = {6'(pl_len), 2'($urandom_range(0, 2))};
         xs     = hdr;
         for (int i = 0; i < pl_len; i++) begin
            pl[i] = 8'($urandom);
            xs    = xs ^ pl[i];
         end
         par = ($urandom_range(0, 1) == 1) ? xs : (xs ^ 8'($urandom_range(1, 255)));
         send_pkt(hdr, par, int'($urandom_range(0, pl_len)), int'($urandom_range(1, 3)),
                  1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage directly downstream of router_fsm in the 1x3 router.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and the input byte stream.
- Produces the byte written into the destination FIFO (dout), plus the packet-status flags low_pkt_valid and parity_done that router_fsm consumes, and a parity error flag err.
- Packet format: header byte (addr = [1:0], payload length = [7:2]), payload bytes, then one parity byte equal to the XOR of header and all payload bytes.

Parameters:
- DATA_W, 8, byte width of data_in, dout and all internal byte registers.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pkt_valid  in  1  high while header/payload bytes are driven; low while the parity byte is driven.
- data_in  in  DATA_W  input byte.
- fifo_full  in  1  selected destination FIFO is full.
- detect_add  in  1  FSM in DECODE_ADDRESS.
- lfd_state  in  1  FSM in LOAD_FIRST_DATA.
- ld_state  in  1  FSM in LOAD_DATA.
- laf_state  in  1  FSM in LOAD_AFTER_FULL.
- full_state  in  1  FSM in FIFO_FULL_STATE.
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR; clears low_pkt_valid.
- dout  out  DATA_W  byte to destination FIFO.
- parity_done  out  1  parity byte captured.
- low_pkt_valid  out  1  pkt_valid fell while loading.
- err  out  1  received parity differs from computed parity.

Behaviour:
- Reset (asynchronous, active-high): clears dout, parity_done, low_pkt_valid, err, and the internal header_byte, hold_byte, int_parity and pkt_parity registers to 0. Assertion mid-packet aborts the packet immediately; there is no partial state.
- Registers:
  - header_byte: loads data_in when detect_add & pkt_valid & data_in[1:0] != 2'b11.
  - hold_byte: loads data_in when ld_state & fifo_full.
- dout, in priority order:
  - lfd_state → header_byte.
  - ld_state & !fifo_full → data_in.
  - laf_state → hold_byte.
  - otherwise hold.
- Latency: 1 cycle from data_in to dout in LOAD_DATA. The header is presented on dout in the cycle after it was sampled.
- int_parity:
  - Cleared on detect_add.
  - lfd_state → int_parity ^ header_byte.
  - ld_state & pkt_valid & !full_state → int_parity ^ data_in.
  - Otherwise hold.
  - Each payload byte is accumulated exactly once, including a byte stalled by fifo_full.
- pkt_parity: loads data_in when ld_state & !pkt_valid & !fifo_full.
- low_pkt_valid:
  - Set when ld_state & !pkt_valid.
  - Cleared when rst_int_reg.
  - If both are true in the same cycle, set wins.
- parity_done:
  - Cleared on detect_add.
  - Set when (ld_state & !fifo_full & !pkt_valid), or when (laf_state & low_pkt_valid & !parity_done).
  - Once set, holds until the next detect_add.
- err:
  - Cleared on detect_add.
  - When parity_done == 1, err <= (pkt_parity != int_parity); the compare is registered, so err is valid one cycle after parity_done rises.
  - Holds until the next detect_add.
- Invalid address 2'b11: header_byte is not loaded and no other register changes on detect_add except the clears.
- Parity byte arriving while fifo_full: pkt_parity is not loaded in LOAD_DATA. It is captured via the hold_byte/laf_state path, and parity_done is set from laf_state.
- Back-to-back packets: detect_add clears parity_done, err and int_parity in the same edge that may load a new header.

Decomposition:
- Package router_pkg holds DATA_W, ADDR_INVALID = 2'b11, and the header field positions (ADDR_LSB/MSB, LEN_LSB/MSB).
- One natural sub-module, router_parity_acc: int_parity accumulator plus the registered compare producing err.

Test Plan:
- Good packet, addr 01: header 8'h0D, payload 8'h11, 8'h22, 8'h33, parity 8'h0D, fifo_full = 0 → dout sequence 0D, 11, 22, 33; parity_done = 1 the cycle after the parity byte; err = 0.
- Same packet with parity byte 8'h0E → parity_done = 1, then err = 1 one cycle later; err clears on the next detect_add.
- fifo_full asserted for 2 cycles while payload 8'h22 is in LOAD_DATA → hold_byte = 22, dout repeats 22 once in laf_state, int_parity still ends at 8'h0D, err = 0.
- pkt_valid drops while fifo_full = 1 → low_pkt_valid = 1; parity_done is set in laf_state; low_pkt_valid clears on rst_int_reg.
- Header 8'h0F (addr 11) on detect_add → header_byte unchanged; dout unchanged.
- reset asserted mid-payload after 8'h11 → all outputs 0 asynchronously; the next packet 8'h0D… completes with err = 0.
